// File: rtl/accumulator_bank_rmw.sv
// Per-column output accumulator bank for the systolic array.
// Each column owns a DEPTH-entry bank that is either overwritten or
// accumulated into (read-modify-write, signed saturation) by a write
// command that is skewed one cycle per column in normal mode and
// broadcast to every column in test mode. A clear sequencer zeroes all
// banks, and sticky per-column flags record saturation events.
module accumulator_bank_rmw #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PARTIAL_SUM_WIDTH = 19,
  parameter int ACC_WIDTH         = 24,
  parameter int DEPTH             = 16,
  parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   test_mode,
  input  logic                                   wr_en,
  input  logic                                   acc_en,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] psum_in_flat,
  input  logic                                   rd_en,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  output logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0]     psum_out_flat,
  output logic                                   rd_valid,
  input  logic                                   clr_start,
  output logic                                   clr_busy,
  output logic [SYSTOLIC_SIZE-1:0]               ovf_flags
);

  localparam int PSW         = PARTIAL_SUM_WIDTH;
  localparam int CMD_WIDTH   = ADDR_WIDTH + 2;
  localparam int SKEW_STAGES = (SYSTOLIC_SIZE > 1) ? SYSTOLIC_SIZE - 1 : 1;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  clr_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      clr_cnt_q, clr_cnt_d;
  logic                       clr_accept;
  logic                       clearing;

  logic [CMD_WIDTH-1:0]       live_cmd;
  logic [CMD_WIDTH-1:0]       skew_q [SKEW_STAGES];
  logic [CMD_WIDTH-1:0]       skew_d [SKEW_STAGES];
  logic [CMD_WIDTH-1:0]       col_cmd [SYSTOLIC_SIZE];

  logic [ACC_WIDTH-1:0]       rd_word [SYSTOLIC_SIZE];
  logic [SYSTOLIC_SIZE-1:0]   ovf_hit;
  logic [SYSTOLIC_SIZE-1:0]   ovf_q, ovf_d;

  logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0] psum_out_q, psum_out_d;
  logic                               rd_valid_q;

  assign live_cmd = {wr_en, acc_en, wr_addr};
  assign clearing = (state_q == CLEAR);

  // Skew chain next state: shift the command one column per cycle, or
  // flush everything in flight while commands are being broadcast.
  always_comb begin
    for (int k = 0; k < SKEW_STAGES; k++) begin
      skew_d[k] = '0;
    end
    if (!test_mode) begin
      skew_d[0] = live_cmd;
      for (int k = 1; k < SKEW_STAGES; k++) begin
        skew_d[k] = skew_q[k-1];
      end
    end
  end

  // Skew chain registers; empty (no pending writes) after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SKEW_STAGES; k++) begin
        skew_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SKEW_STAGES; k++) begin
        skew_q[k] <= skew_d[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_col
      logic [ACC_WIDTH-1:0]        mem_q [DEPTH];
      logic                        c_wr_en;
      logic                        c_acc_en;
      logic [ADDR_WIDTH-1:0]       c_addr;
      logic                        wr_fire;
      logic signed [ACC_WIDTH-1:0] old_val;
      logic signed [ACC_WIDTH-1:0] ext_psum;
      logic signed [ACC_WIDTH:0]   sum;
      logic                        sum_ovf;
      logic [ACC_WIDTH-1:0]        sat_val;
      logic [ACC_WIDTH-1:0]        wr_val;

      if (gi == 0) begin : g_live
        assign col_cmd[gi] = live_cmd;
      end else begin : g_skew
        assign col_cmd[gi] = test_mode ? live_cmd : skew_q[gi-1];
      end

      assign {c_wr_en, c_acc_en, c_addr} = col_cmd[gi];
      assign wr_fire  = c_wr_en && !clearing;

      assign old_val  = mem_q[c_addr];
      assign ext_psum = ACC_WIDTH'(signed'(psum_in_flat[gi*PSW +: PSW]));
      assign sum      = {old_val[ACC_WIDTH-1], old_val} + {ext_psum[ACC_WIDTH-1], ext_psum};
      assign sum_ovf  = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
      assign sat_val  = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      assign wr_val   = !c_acc_en ? ext_psum
                      : sum_ovf   ? sat_val
                                  : sum[ACC_WIDTH-1:0];

      assign ovf_hit[gi] = wr_fire && c_acc_en && sum_ovf;
      assign rd_word[gi] = mem_q[rd_addr];

      // Bank storage: the clear sequencer owns the bank while it runs,
      // otherwise the column command writes the computed value.
      always_ff @(posedge clk) begin
        if (clearing) begin
          mem_q[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
          mem_q[c_addr] <= wr_val;
        end
      end
    end
  endgenerate

  // Clear sequencer: walk every address once, then return to idle.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d    = CLEAR;
          clr_cnt_d  = '0;
          clr_accept = 1'b1;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Clear sequencer state and address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sticky overflow flags: accumulate new saturation events, wiped by a clear.
  always_comb begin
    ovf_d = ovf_q | ovf_hit;
    if (clr_accept) begin
      ovf_d = '0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Read data next state: capture every column on a read, hold otherwise.
  always_comb begin
    psum_out_d = psum_out_q;
    if (rd_en) begin
      for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
        psum_out_d[i*ACC_WIDTH +: ACC_WIDTH] = rd_word[i];
      end
    end
  end

  // Registered read port; sees the pre-write value on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      psum_out_q <= psum_out_d;
      rd_valid_q <= rd_en;
    end
  end

  assign psum_out_flat = psum_out_q;
  assign rd_valid      = rd_valid_q;
  assign clr_busy      = clearing;
  assign ovf_flags     = ovf_q;

endmodule

// File: tb/tb_accumulator_bank_rmw.sv
// Directed self-checking bench for accumulator_bank_rmw: clear sequencing,
// skewed and broadcast writes, saturation flags, read/write ordering and
// reset during a clear.
module tb_accumulator_bank_rmw;

  localparam int N   = 8;
  localparam int PSW = 19;
  localparam int AW  = 24;
  localparam int D   = 16;
  localparam int ADW = 4;

  logic               clk;
  logic               rst_n;
  logic               test_mode;
  logic               wr_en;
  logic               acc_en;
  logic [ADW-1:0]     wr_addr;
  logic [PSW*N-1:0]   psum_in_flat;
  logic               rd_en;
  logic [ADW-1:0]     rd_addr;
  logic [AW*N-1:0]    psum_out_flat;
  logic               rd_valid;
  logic               clr_start;
  logic               clr_busy;
  logic [N-1:0]       ovf_flags;

  int checks;
  int failures;

  accumulator_bank_rmw #(
    .SYSTOLIC_SIZE(N),
    .PARTIAL_SUM_WIDTH(PSW),
    .ACC_WIDTH(AW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .test_mode(test_mode),
    .wr_en(wr_en),
    .acc_en(acc_en),
    .wr_addr(wr_addr),
    .psum_in_flat(psum_in_flat),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .psum_out_flat(psum_out_flat),
    .rd_valid(rd_valid),
    .clr_start(clr_start),
    .clr_busy(clr_busy),
    .ovf_flags(ovf_flags)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One comparison point: count it, and report and count a mismatch.
  task automatic checkOutput(input string tag, input logic [AW*N-1:0] observed,
                             input logic [AW*N-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Same accumulator value replicated into every column slot.
  function automatic logic [AW*N-1:0] allCols(input logic [AW-1:0] v);
    logic [AW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  // Same partial sum replicated into every column slot.
  function automatic logic [PSW*N-1:0] psumAll(input logic [PSW-1:0] v);
    logic [PSW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*PSW +: PSW] = v;
    return r;
  endfunction

  // Wait (bounded) for an in-progress clear to finish.
  task automatic waitClearDone();
    int guard;
    guard = 0;
    while (clr_busy && guard < 40) begin
      step();
      guard++;
    end
    checkOutput("clear_done", (AW*N)'(clr_busy), (AW*N)'(0));
  endtask

  // Issue a single-cycle read and leave rd_en low afterwards.
  task automatic applyStimulus(input logic [ADW-1:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    step();
    rd_en   = 1'b0;
  endtask

  initial begin
    logic [AW*N-1:0]  expv;
    logic [PSW*N-1:0] ps;
    int busyCycles;
    int guard;

    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    test_mode    = 1'b0;
    wr_en        = 1'b0;
    acc_en       = 1'b0;
    wr_addr      = '0;
    psum_in_flat = '0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    clr_start    = 1'b0;

    // Reset values
    step();
    step();
    checkOutput("rst_psum_out", psum_out_flat, '0);
    checkOutput("rst_rd_valid", (AW*N)'(rd_valid), (AW*N)'(0));
    checkOutput("rst_clr_busy", (AW*N)'(clr_busy), (AW*N)'(0));
    checkOutput("rst_ovf", (AW*N)'(ovf_flags), (AW*N)'(0));
    rst_n = 1'b1;
    step();

    // Clear after reset: busy for exactly DEPTH cycles
    clr_start = 1'b1;
    step();
    clr_start  = 1'b0;
    busyCycles = 0;
    guard      = 0;
    while (clr_busy && guard < 40) begin
      busyCycles++;
      step();
      guard++;
    end
    checkOutput("clr_busy_cycles", (AW*N)'(busyCycles), (AW*N)'(D));

    // Every address reads back zero, valid one cycle after the request
    for (int a = 0; a < D; a++) begin
      applyStimulus(ADW'(a));
      checkOutput($sformatf("clr_valid_%0d", a), (AW*N)'(rd_valid), (AW*N)'(1));
      checkOutput($sformatf("clr_data_%0d", a), psum_out_flat, '0);
    end
    step();
    checkOutput("rd_valid_low", (AW*N)'(rd_valid), (AW*N)'(0));

    // Skewed overwrite of addr 3: column i sees its value only at t0+i
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) ps[i*PSW +: PSW] = (i == k) ? PSW'(i + 1) : PSW'(99);
      psum_in_flat = ps;
      wr_en   = (k == 0);
      acc_en  = 1'b0;
      wr_addr = 4'd3;
      rd_en   = (k == 3);
      rd_addr = 4'd3;
      step();
      if (k == 3) begin
        for (int i = 0; i < N; i++) expv[i*AW +: AW] = (i < 3) ? AW'(i + 1) : AW'(0);
        checkOutput("skew_partial", psum_out_flat, expv);
      end
    end
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    psum_in_flat = '0;
    applyStimulus(4'd3);
    for (int i = 0; i < N; i++) expv[i*AW +: AW] = AW'(i + 1);
    checkOutput("skew_final", psum_out_flat, expv);

    // Broadcast accumulate of -7 three times into addr 5
    test_mode = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wr_en        = 1'b1;
      acc_en       = 1'b1;
      wr_addr      = 4'd5;
      psum_in_flat = psumAll(-19'sd7);
      rd_en        = (j == 1);
      rd_addr      = 4'd5;
      step();
      if (j == 1) checkOutput("bcast_first", psum_out_flat, allCols(24'hFFFFF9));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    applyStimulus(4'd5);
    checkOutput("bcast_sum", psum_out_flat, allCols(24'hFFFFEB));
    test_mode = 1'b0;

    // Saturation in column 2 at addr 0
    psum_in_flat = '0;
    psum_in_flat[2*PSW +: PSW] = 19'h3FFFF;
    wr_en   = 1'b1;
    acc_en  = 1'b1;
    wr_addr = 4'd0;
    for (int k = 0; k < 32; k++) step();
    wr_en = 1'b0;
    for (int k = 0; k < N; k++) step();
    checkOutput("sat_ovf_before", (AW*N)'(ovf_flags), (AW*N)'(0));
    applyStimulus(4'd0);
    expv = '0;
    expv[2*AW +: AW] = 24'h7FFFE0;
    checkOutput("sat_below_max", psum_out_flat, expv);
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) step();
    wr_en = 1'b0;
    for (int k = 0; k < N; k++) step();
    checkOutput("sat_ovf_set", (AW*N)'(ovf_flags), (AW*N)'(8'b0000_0100));
    applyStimulus(4'd0);
    expv = '0;
    expv[2*AW +: AW] = 24'h7FFFFF;
    checkOutput("sat_value", psum_out_flat, expv);
    psum_in_flat = '0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    checkOutput("sat_ovf_cleared", (AW*N)'(ovf_flags), (AW*N)'(0));
    checkOutput("sat_clr_busy", (AW*N)'(clr_busy), (AW*N)'(1));
    waitClearDone();

    // Read and accumulate to the same address in the same cycle
    test_mode    = 1'b1;
    wr_en        = 1'b1;
    acc_en       = 1'b0;
    wr_addr      = 4'd1;
    psum_in_flat = psumAll(19'd10);
    step();
    acc_en       = 1'b1;
    psum_in_flat = psumAll(19'd5);
    rd_en        = 1'b1;
    rd_addr      = 4'd1;
    step();
    checkOutput("rmw_old_valid", (AW*N)'(rd_valid), (AW*N)'(1));
    checkOutput("rmw_old_value", psum_out_flat, allCols(24'd10));
    wr_en = 1'b0;
    applyStimulus(4'd1);
    checkOutput("rmw_new_value", psum_out_flat, allCols(24'd15));
    step();
    checkOutput("hold_valid_low", (AW*N)'(rd_valid), (AW*N)'(0));
    checkOutput("hold_data", psum_out_flat, allCols(24'd15));

    // Clear started mid-burst: writes during the clear are dropped
    wr_en        = 1'b1;
    acc_en       = 1'b0;
    wr_addr      = 4'd0;
    psum_in_flat = psumAll(19'd77);
    clr_start    = 1'b1;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    wr_en = 1'b0;
    applyStimulus(4'd0);
    checkOutput("clr_drop_data", psum_out_flat, '0);
    checkOutput("clr_mid_busy", (AW*N)'(clr_busy), (AW*N)'(1));
    checkOutput("clr_mid_valid", (AW*N)'(rd_valid), (AW*N)'(1));

    // Asynchronous reset in the middle of the clear
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", (AW*N)'(clr_busy), (AW*N)'(0));
    checkOutput("rst_mid_ovf", (AW*N)'(ovf_flags), (AW*N)'(0));
    checkOutput("rst_mid_valid", (AW*N)'(rd_valid), (AW*N)'(0));
    checkOutput("rst_mid_data", psum_out_flat, '0);
    step();
    rst_n     = 1'b1;
    test_mode = 1'b0;
    step();
    checkOutput("post_rst_busy", (AW*N)'(clr_busy), (AW*N)'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_bank_rmw.md
Name: accumulator_bank_rmw

Overview:
Per-column output accumulator bank that sits below the systolic array and collects partial sums from every column. It is the successor to the write-only accumulator memory and adds the following:
- Read-modify-write accumulation with signed saturation.
- Configurable depth and accumulator width.
- Registered read port with valid.
- Hardware clear sequencer.
- Sticky per-column overflow flags.

Write commands skew by column in normal mode and broadcast to all columns in test mode.

Parameters:
SYSTOLIC_SIZE, 8, number of columns / memory banks
PARTIAL_SUM_WIDTH, 19, signed width of each incoming partial sum
ACC_WIDTH, 24, signed width of each stored entry (must be >= PARTIAL_SUM_WIDTH)
DEPTH, 16, entries per column bank
ADDR_WIDTH, $clog2(DEPTH), address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
test_mode  input  1  1 = broadcast commands to all columns with no skew
wr_en  input  1  write command valid (column 0 timing)
acc_en  input  1  1 = accumulate into entry, 0 = overwrite entry
wr_addr  input  ADDR_WIDTH  write address (column 0 timing)
psum_in_flat  input  PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE  column i at bits [i*PSW +: PSW]
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address, same for all columns
psum_out_flat  output  ACC_WIDTH*SYSTOLIC_SIZE  registered read data, column i at [i*ACC_WIDTH +: ACC_WIDTH]
rd_valid  output  1  psum_out_flat updated this cycle
clr_start  input  1  pulse: start clearing all entries
clr_busy  output  1  clear sequence in progress
ovf_flags  output  SYSTOLIC_SIZE  sticky saturation flag per column

Behaviour:
- Reset: all skew registers = 0 (no pending writes); psum_out_flat = 0; rd_valid = 0; clr_busy = 0; ovf_flags = 0; clear FSM = IDLE. Memory contents are not reset; software must issue a clear after reset.
- Command skew: {wr_en, acc_en, wr_addr} is packed and passed through a SYSTOLIC_SIZE-1 stage shift chain.
  - Normal mode: column i uses the stage i-1 output (column 0 uses the live command), so a command issued at cycle t writes column i at cycle t+i.
  - psum for column i is sampled in the cycle the command reaches that column; the input data is already skewed by the array.
- test_mode = 1: every column uses the live command, so all columns write at cycle t. While test_mode = 1 the shift chain loads zeros, which flushes in-flight commands. A command issued in the last normal-mode cycle before test_mode rises is dropped for columns ≥1.
- Write arithmetic: psum is sign-extended to ACC_WIDTH.
  - Overwrite: mem[a] <= ext(psum).
  - Accumulate: sum = mem[a] + ext(psum), computed at ACC_WIDTH+1 bits. If the sum exceeds the signed max/min, store max/min and set ovf_flags[i].
  - Read of the old value is combinational within the same cycle, so back-to-back accumulates to the same address every cycle are exact.
- ovf_flags: sticky; cleared only by reset or an accepted clr_start.
- Read: rd_en at cycle t -> psum_out_flat and rd_valid = 1 at t+1.
  - With rd_en = 0, rd_valid = 0 and psum_out_flat holds its value.
  - A read and write to the same column and address in the same cycle returns the pre-write value.
- Clear FSM states are IDLE and CLEAR.
  - IDLE: clr_start -> CLEAR, counter = 0, ovf_flags cleared.
  - CLEAR: each cycle writes 0 to entry counter in all columns, then counter++. After DEPTH-1 -> IDLE.
  - clr_busy = 1 exactly for the DEPTH cycles of CLEAR. clr_start while busy is ignored.
  - Column writes arriving during CLEAR are dropped, and skew registers still shift.
  - Reads during CLEAR are allowed and return current contents.
- Reset mid-operation: FSM, skew chain, flags and outputs return to their reset values immediately. Memory state is undefined until a clear completes.

Test Plan:
- Reset, clr_start, wait: clr_busy is high 16 cycles; then reading addr 0..15 returns 0 in all columns with rd_valid one cycle after each rd_en.
- Normal mode, wr_en=1 acc_en=0 addr=3 at t0 with column i psum = i+1 at t0+i: read addr 3 gives column i = i+1; no column writes before t0+i.
- test_mode=1, three accumulates to addr 5 with all psums = -7 each cycle: read gives -21 in every column, and all columns update on the same cycle.
- Accumulate +max partial sum (2^18-1) into addr 0 repeatedly in column 2: the value saturates at 2^23-1 and ovf_flags = 8'b0000_0100; a subsequent clr_start clears the flag.
- Same-cycle rd_en and write to addr 1 (old 10, add 5): rd data = 10 next cycle, and a following read gives 15.
- clr_start issued mid-write burst and rst_n pulsed during CLEAR: writes during CLEAR are dropped, and after reset clr_busy = 0, ovf_flags = 0 and rd_valid = 0.
